// File: rtl/fetch_pkg.sv
// Shared constants and IF/ID payload type for the fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  localparam logic [XLEN-1:0] RESET_PC   = XLEN'(32'h0000_0000);
  localparam logic [XLEN-1:0] NOP_INSTR  = XLEN'(32'h0000_0000);
  localparam logic [XLEN-1:0] PC_INC     = XLEN'(32'd4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(32'd3);

  localparam logic [1:0] JUMP_NONE = 2'd0;
  localparam logic [1:0] JUMP_J    = 2'd1;
  localparam logic [1:0] JUMP_JR   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

endpackage

// File: rtl/next_pc_mux.sv
// Next-PC priority select: jr > j/jal > taken branch > sequential; result word aligned.
module next_pc_mux
  import fetch_pkg::*;
(
  input  logic [XLEN-1:0] pc,
  input  logic            pcsrc,
  input  logic [1:0]      jump,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] jump_target,
  input  logic [XLEN-1:0] jr_target,
  output logic [XLEN-1:0] pc_plus4_c,
  output logic [XLEN-1:0] next_pc_c
);

  logic [XLEN-1:0] sel;

  always_comb begin
    pc_plus4_c = pc + PC_INC;
    sel        = pc_plus4_c;
    if (jump == JUMP_JR)     sel = jr_target;
    else if (jump == JUMP_J) sel = jump_target;
    else if (pcsrc)          sel = branch_target;
    next_pc_c = sel & ALIGN_MASK;
  end

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: PC register, IF/ID pipeline register and optional perf counters.
// Define FETCH_PERF_CNT_EN to build the StallCount/FlushCount counters; otherwise they read 0.
module fetch_stage_ctrl
  import fetch_pkg::*;
(
  input  logic             Clk,
  input  logic             Rst,
  input  logic             PCWrite,
  input  logic             IFIDWrite,
  input  logic             FlushSignal,
  input  logic             PCsrc,
  input  logic [1:0]       Jump,
  input  logic [XLEN-1:0]  BranchTarget,
  input  logic [XLEN-1:0]  JumpTarget,
  input  logic [XLEN-1:0]  JRTarget,
  input  logic [XLEN-1:0]  InstrIn,
  output logic [XLEN-1:0]  PC,
  output logic [XLEN-1:0]  IFIDInstr,
  output logic [XLEN-1:0]  IFIDPCPlus4,
  output logic             IFIDValid,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount
);

  logic [XLEN-1:0] pc_plus4_c;
  logic [XLEN-1:0] next_pc_c;
  ifid_t           ifid_q;

  next_pc_mux u_next_pc_mux (
    .pc            (PC),
    .pcsrc         (PCsrc),
    .jump          (Jump),
    .branch_target (BranchTarget),
    .jump_target   (JumpTarget),
    .jr_target     (JRTarget),
    .pc_plus4_c    (pc_plus4_c),
    .next_pc_c     (next_pc_c)
  );

  // PC holds on stall; a pending redirect is simply re-presented next cycle.
  always_ff @(posedge Clk) begin
    if (Rst)           PC <= RESET_PC;
    else if (!PCWrite) PC <= next_pc_c;
  end

  // Stall has priority over flush on the IF/ID register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      ifid_q <= IFID_BUBBLE;
    end else if (!IFIDWrite) begin
      if (FlushSignal) ifid_q <= IFID_BUBBLE;
      else             ifid_q <= '{instr: InstrIn, pc_plus4: pc_plus4_c, valid: 1'b1};
    end
  end

  assign IFIDInstr   = ifid_q.instr;
  assign IFIDPCPlus4 = ifid_q.pc_plus4;
  assign IFIDValid   = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
  // Saturating event counters; only effective flushes are counted.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      StallCount <= '0;
      FlushCount <= '0;
    end else begin
      if (PCWrite && (StallCount != CNT_MAX))
        StallCount <= StallCount + CNT_W'(1);
      if (FlushSignal && !IFIDWrite && (FlushCount != CNT_MAX))
        FlushCount <= FlushCount + CNT_W'(1);
    end
  end
`else
  assign StallCount = '0;
  assign FlushCount = '0;
`endif

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Directed self-checking bench for fetch_stage_ctrl (counter expectations follow FETCH_PERF_CNT_EN).
module tb_fetch_stage_ctrl;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Rst, PCWrite, IFIDWrite, FlushSignal, PCsrc;
  logic [1:0]  Jump;
  logic [31:0] BranchTarget, JumpTarget, JRTarget, InstrIn;
  logic [31:0] PC, IFIDInstr, IFIDPCPlus4;
  logic        IFIDValid;
  logic [15:0] StallCount, FlushCount;

  int total = 0;
  int bad   = 0;

  fetch_stage_ctrl dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .PCWrite      (PCWrite),
    .IFIDWrite    (IFIDWrite),
    .FlushSignal  (FlushSignal),
    .PCsrc        (PCsrc),
    .Jump         (Jump),
    .BranchTarget (BranchTarget),
    .JumpTarget   (JumpTarget),
    .JRTarget     (JRTarget),
    .InstrIn      (InstrIn),
    .PC           (PC),
    .IFIDInstr    (IFIDInstr),
    .IFIDPCPlus4  (IFIDPCPlus4),
    .IFIDValid    (IFIDValid),
    .StallCount   (StallCount),
    .FlushCount   (FlushCount)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] cnt(input int v);
    return PERF ? 16'(v) : 16'd0;
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Rst = 1'b0; PCWrite = 1'b0; IFIDWrite = 1'b0; FlushSignal = 1'b0;
    PCsrc = 1'b0; Jump = 2'd0;
    BranchTarget = 32'h0; JumpTarget = 32'h0; JRTarget = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    Rst = 1'b1; PCWrite = 1'b1; Jump = 2'd1; JumpTarget = 32'h1234;
    InstrIn = 32'h2008_0001;
    tick(); tick();
    idle_inputs();
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=%h", PC, 32'h0); end
    total++; if (IFIDInstr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=%h", IFIDInstr, 32'h0); end
    total++; if (IFIDPCPlus4 !== 32'h0) begin bad++; $display("FAIL reset_pcp4 got=%h exp=%h", IFIDPCPlus4, 32'h0); end
    total++; if (IFIDValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", IFIDValid); end
    total++; if (StallCount !== 16'd0) begin bad++; $display("FAIL reset_stallcnt got=%0d exp=0", StallCount); end
    total++; if (FlushCount !== 16'd0) begin bad++; $display("FAIL reset_flushcnt got=%0d exp=0", FlushCount); end
  endtask

  // Three more idle edges after reset: PC 4,8,12 with IF/ID trailing by one.
  task automatic test_sequential();
    logic [31:0] exp_pc;
    for (int i = 1; i <= 3; i++) begin
      tick();
      exp_pc = 32'(4 * i);
      total++; if (PC !== exp_pc) begin bad++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, PC, exp_pc); end
      total++; if (IFIDPCPlus4 !== exp_pc) begin bad++; $display("FAIL seq_pcp4[%0d] got=%h exp=%h", i, IFIDPCPlus4, exp_pc); end
      total++; if (IFIDValid !== 1'b1) begin bad++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, IFIDValid); end
      total++; if (IFIDInstr !== 32'h2008_0001) begin bad++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, IFIDInstr, 32'h2008_0001); end
    end
  endtask

  task automatic test_stall();
    // PC=12 -> j 0x43 lands on 0x40; IF/ID picks up PC+4=0x10.
    Jump = 2'd1; JumpTarget = 32'h43; InstrIn = 32'h1111_2222;
    tick();
    total++; if (PC !== 32'h40) begin bad++; $display("FAIL j_pc got=%h exp=%h", PC, 32'h40); end
    total++; if (IFIDPCPlus4 !== 32'h10) begin bad++; $display("FAIL j_pcp4 got=%h exp=%h", IFIDPCPlus4, 32'h10); end
    idle_inputs();
    PCWrite = 1'b1; IFIDWrite = 1'b1; InstrIn = 32'hDEAD_BEEF;
    tick(); tick();
    total++; if (PC !== 32'h40) begin bad++; $display("FAIL stall_pc got=%h exp=%h", PC, 32'h40); end
    total++; if (IFIDInstr !== 32'h1111_2222) begin bad++; $display("FAIL stall_instr got=%h exp=%h", IFIDInstr, 32'h1111_2222); end
    total++; if (IFIDPCPlus4 !== 32'h10) begin bad++; $display("FAIL stall_pcp4 got=%h exp=%h", IFIDPCPlus4, 32'h10); end
    total++; if (StallCount !== cnt(2)) begin bad++; $display("FAIL stall_cnt got=%0d exp=%0d", StallCount, cnt(2)); end
    idle_inputs();
  endtask

  task automatic test_branch_flush();
    Jump = 2'd1; JumpTarget = 32'h10; InstrIn = 32'h0000_0020;
    tick();
    total++; if (PC !== 32'h10) begin bad++; $display("FAIL setup_pc got=%h exp=%h", PC, 32'h10); end
    idle_inputs();
    PCsrc = 1'b1; BranchTarget = 32'h102; FlushSignal = 1'b1;
    tick();
    total++; if (PC !== 32'h100) begin bad++; $display("FAIL br_pc got=%h exp=%h", PC, 32'h100); end
    total++; if (IFIDInstr !== 32'h0) begin bad++; $display("FAIL flush_instr got=%h exp=0", IFIDInstr); end
    total++; if (IFIDPCPlus4 !== 32'h0) begin bad++; $display("FAIL flush_pcp4 got=%h exp=0", IFIDPCPlus4); end
    total++; if (IFIDValid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%b exp=0", IFIDValid); end
    total++; if (FlushCount !== cnt(1)) begin bad++; $display("FAIL flush_cnt got=%0d exp=%0d", FlushCount, cnt(1)); end
    idle_inputs();
  endtask

  task automatic test_priority();
    Jump = 2'd2; JRTarget = 32'h203; PCsrc = 1'b1; BranchTarget = 32'h500; JumpTarget = 32'h600;
    InstrIn = 32'hABCD_0001;
    tick();
    total++; if (PC !== 32'h200) begin bad++; $display("FAIL jr_pc got=%h exp=%h", PC, 32'h200); end
    total++; if (IFIDPCPlus4 !== 32'h104) begin bad++; $display("FAIL jr_pcp4 got=%h exp=%h", IFIDPCPlus4, 32'h104); end
    total++; if (IFIDValid !== 1'b1) begin bad++; $display("FAIL jr_valid got=%b exp=1", IFIDValid); end
    // j beats branch; then Jump=3 is treated as no jump.
    Jump = 2'd1; JumpTarget = 32'h300;
    tick();
    total++; if (PC !== 32'h300) begin bad++; $display("FAIL j_over_br got=%h exp=%h", PC, 32'h300); end
    Jump = 2'd3; PCsrc = 1'b0;
    tick();
    total++; if (PC !== 32'h304) begin bad++; $display("FAIL jump3 got=%h exp=%h", PC, 32'h304); end
    idle_inputs();
  endtask

  task automatic test_stall_beats_flush();
    PCWrite = 1'b1; IFIDWrite = 1'b1; FlushSignal = 1'b1; Jump = 2'd1; JumpTarget = 32'h800;
    InstrIn = 32'h5555_5555;
    tick();
    total++; if (PC !== 32'h304) begin bad++; $display("FAIL hold_pc got=%h exp=%h", PC, 32'h304); end
    total++; if (IFIDPCPlus4 !== 32'h304) begin bad++; $display("FAIL hold_pcp4 got=%h exp=%h", IFIDPCPlus4, 32'h304); end
    total++; if (IFIDValid !== 1'b1) begin bad++; $display("FAIL hold_valid got=%b exp=1", IFIDValid); end
    total++; if (FlushCount !== cnt(1)) begin bad++; $display("FAIL hold_flushcnt got=%0d exp=%0d", FlushCount, cnt(1)); end
    total++; if (StallCount !== cnt(3)) begin bad++; $display("FAIL hold_stallcnt got=%0d exp=%0d", StallCount, cnt(3)); end
    idle_inputs();
  endtask

  task automatic test_independent();
    // IF/ID stalled only: PC advances, IF/ID holds.
    IFIDWrite = 1'b1; InstrIn = 32'h7777_0000;
    tick();
    total++; if (PC !== 32'h308) begin bad++; $display("FAIL ind_pc_adv got=%h exp=%h", PC, 32'h308); end
    total++; if (IFIDPCPlus4 !== 32'h304) begin bad++; $display("FAIL ind_ifid_hold got=%h exp=%h", IFIDPCPlus4, 32'h304); end
    // PC stalled only: PC holds, IF/ID reloads.
    IFIDWrite = 1'b0; PCWrite = 1'b1;
    tick();
    total++; if (PC !== 32'h308) begin bad++; $display("FAIL ind_pc_hold got=%h exp=%h", PC, 32'h308); end
    total++; if (IFIDPCPlus4 !== 32'h30C) begin bad++; $display("FAIL ind_ifid_load got=%h exp=%h", IFIDPCPlus4, 32'h30C); end
    total++; if (IFIDInstr !== 32'h7777_0000) begin bad++; $display("FAIL ind_instr got=%h exp=%h", IFIDInstr, 32'h7777_0000); end
    total++; if (StallCount !== cnt(4)) begin bad++; $display("FAIL ind_stallcnt got=%0d exp=%0d", StallCount, cnt(4)); end
    idle_inputs();
  endtask

  task automatic test_wrap_and_midreset();
    Jump = 2'd1; JumpTarget = 32'hFFFF_FFFF;
    tick();
    total++; if (PC !== 32'hFFFF_FFFC) begin bad++; $display("FAIL top_pc got=%h exp=%h", PC, 32'hFFFF_FFFC); end
    idle_inputs();
    tick();
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h exp=0", PC); end
    total++; if (IFIDPCPlus4 !== 32'h0) begin bad++; $display("FAIL wrap_pcp4 got=%h exp=0", IFIDPCPlus4); end
    total++; if (IFIDValid !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b exp=1", IFIDValid); end
    // Stall with a pending redirect, then reset in the middle of it.
    PCWrite = 1'b1; IFIDWrite = 1'b1; Jump = 2'd1; JumpTarget = 32'h900;
    tick();
    Rst = 1'b1; FlushSignal = 1'b1;
    tick();
    total++; if (PC !== 32'h0) begin bad++; $display("FAIL mrst_pc got=%h exp=0", PC); end
    total++; if (IFIDInstr !== 32'h0) begin bad++; $display("FAIL mrst_instr got=%h exp=0", IFIDInstr); end
    total++; if (IFIDPCPlus4 !== 32'h0) begin bad++; $display("FAIL mrst_pcp4 got=%h exp=0", IFIDPCPlus4); end
    total++; if (IFIDValid !== 1'b0) begin bad++; $display("FAIL mrst_valid got=%b exp=0", IFIDValid); end
    total++; if (StallCount !== 16'd0) begin bad++; $display("FAIL mrst_stallcnt got=%0d exp=0", StallCount); end
    total++; if (FlushCount !== 16'd0) begin bad++; $display("FAIL mrst_flushcnt got=%0d exp=0", FlushCount); end
    idle_inputs();
    InstrIn = 32'h2008_0001;
    tick();
    total++; if (PC !== 32'h4) begin bad++; $display("FAIL post_rst_pc got=%h exp=%h", PC, 32'h4); end
    total++; if (IFIDValid !== 1'b1) begin bad++; $display("FAIL post_rst_valid got=%b exp=1", IFIDValid); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_branch_flush();
    test_priority();
    test_stall_beats_flush();
    test_independent();
    test_wrap_and_midreset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage_ctrl.md
FETCH_STAGE_CTRL -- requirements
Module: fetch_stage_ctrl

Interface
REQ-001 SHALL have a single clock Clk; reset Rst is synchronous and active-high.
REQ-002 SHALL expose ports (name  direction  width  meaning):
- Clk  in  1  rising-edge clock
- Rst  in  1  sync active-high reset
- PCWrite  in  1  1 = hold PC (stall request from hazard detection)
- IFIDWrite  in  1  1 = hold IF/ID register (stall)
- FlushSignal  in  1  1 = replace IF/ID contents with bubble
- PCsrc  in  1  1 = taken branch, redirect to BranchTarget
- Jump  in  2  1 = j/jal (JumpTarget), 2 = jr (JRTarget), 0/3 = none
- BranchTarget  in  32  branch target address
- JumpTarget  in  32  j/jal target address
- JRTarget  in  32  register jump target
- InstrIn  in  32  instruction memory read data for current PC (combinational)
- PC  out  32  current fetch address
- IFIDInstr  out  32  IF/ID instruction
- IFIDPCPlus4  out  32  IF/ID PC+4
- IFIDValid  out  1  1 = IF/ID holds a real instruction
- StallCount  out  16  cycles with PCWrite=1 (perf)
- FlushCount  out  16  cycles with effective flush (perf)

Function
REQ-003 SHALL compute NextPC with priority: Jump==2 -> JRTarget; Jump==1 -> JumpTarget; PCsrc==1 -> BranchTarget; else PC+4.
REQ-004 SHALL force NextPC[1:0] to 00; low target bits ignored.
REQ-005 SHALL load PC <= NextPC on each Clk edge where PCWrite==0; SHALL hold PC when PCWrite==1, including when a redirect is present (redirect is re-presented next cycle).
REQ-006 SHALL let PC+4 wrap modulo 2^32 (0xFFFFFFFC -> 0x00000000), no flag.
REQ-007 SHALL, when IFIDWrite==0 and FlushSignal==0, load IFIDInstr <= InstrIn, IFIDPCPlus4 <= PC+4, IFIDValid <= 1 (one-cycle IF-to-ID latency).
REQ-008 SHALL, when IFIDWrite==0 and FlushSignal==1, load IFIDInstr <= NOP (0x00000000), IFIDPCPlus4 <= 0, IFIDValid <= 0.
REQ-009 SHALL hold all IF/ID outputs when IFIDWrite==1; stall beats flush (flush dropped that cycle).
REQ-010 SHALL treat PCWrite and IFIDWrite independently; no cross-gating.
REQ-011 SHALL increment StallCount each cycle PCWrite==1, saturating at 0xFFFF.
REQ-012 SHALL increment FlushCount each cycle FlushSignal==1 and IFIDWrite==0, saturating at 0xFFFF.

Reset
REQ-013 SHALL, when Rst==1 at a Clk edge, set PC=RESET_PC (0x00000000), IFIDInstr=NOP, IFIDPCPlus4=0, IFIDValid=0, StallCount=0, FlushCount=0, overriding all other inputs.
REQ-014 SHALL, in the first cycle after Rst deasserts, present PC=0 and IFIDValid=0; the first instruction is valid in IF/ID one cycle later.
REQ-015 SHALL abandon any in-progress stall or redirect on Rst mid-operation; no state survives reset.

Configuration
REQ-016 SHALL compile the perf counters (REQ-011, REQ-012) only when FETCH_PERF_CNT_EN is defined.
REQ-017 SHALL, without FETCH_PERF_CNT_EN, keep StallCount and FlushCount ports and drive them constant 0, with no counter flops.

Structure
REQ-018 SHALL place RESET_PC, NOP_INSTR, PC_INC (4), JUMP_NONE/JUMP_J/JUMP_JR encodings and the 16-bit counter width in shared package fetch_pkg.
REQ-019 SHALL implement the REQ-003/004 priority select in one combinational sub-module next_pc_mux; all registers stay in fetch_stage_ctrl.

Verification
REQ-020 Reset, then 4 idle cycles with InstrIn=0x20080001 -> PC 0,4,8,12; IFIDPCPlus4 4,8,12; IFIDValid=1 from cycle 2.
REQ-021 PC=0x40, PCWrite=IFIDWrite=1 for 2 cycles -> PC stays 0x40, IF/ID unchanged, StallCount=2 (macro on) / 0 (macro off).
REQ-022 PC=0x10, PCsrc=1, BranchTarget=0x100, FlushSignal=1 -> next PC=0x100, IFIDInstr=0, IFIDValid=0, FlushCount=1.
REQ-023 Jump=2, JRTarget=0x203, PCsrc=1 same cycle -> PC=0x200 (jr wins, low bits cleared).
REQ-024 PCWrite=1, IFIDWrite=1, FlushSignal=1, Jump=1 simultaneous -> PC and IF/ID held, FlushCount unchanged.
REQ-025 PC=0xFFFFFFFC idle -> PC=0x00000000; Rst asserted mid-stall -> all outputs at REQ-013 values next edge.
